// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax datapath: FSM state encodings,
// the most-negative-value constant builder and the beats-per-vector helper.
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Returned 64 bits wide; callers size-cast to their element width.
    function automatic logic [63:0] most_neg(input int unsigned width);
        logic [63:0] v;
        v = '1;
        v = v << (width - 1);
        return v;
    endfunction

    function automatic int unsigned beat_count(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/max_lane_tree.sv
// Combinational pairwise signed-max tree across the lanes of one beat.
// MAX_REDUCE_ARGMAX_EN adds the winning lane index output.
module max_lane_tree
    import softmax_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LANES     = 4,
    localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*DATA_SIZE-1:0] data_i,
    input  logic [LANES-1:0]           mask_i,
`ifdef MAX_REDUCE_ARGMAX_EN
    output logic [LW-1:0]              idx_o,
`endif
    output logic [DATA_SIZE-1:0]       max_o
);

    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam logic [DATA_SIZE-1:0] MOST_NEG = DATA_SIZE'(most_neg(DATA_SIZE));

    // Reduction is done in place; the array is doubled so 2*i+1 never leaves range.
    always_comb begin
        logic signed [DATA_SIZE-1:0] val [2*LANES];
`ifdef MAX_REDUCE_ARGMAX_EN
        logic [LW-1:0] id [2*LANES];
`endif
        int cnt;
        for (int i = 0; i < 2*LANES; i++) begin
            val[i] = MOST_NEG;
`ifdef MAX_REDUCE_ARGMAX_EN
            id[i] = '0;
`endif
        end
        for (int i = 0; i < LANES; i++) begin
            val[i] = mask_i[i] ? data_i[i*DATA_SIZE +: DATA_SIZE] : MOST_NEG;
`ifdef MAX_REDUCE_ARGMAX_EN
            id[i] = LW'(i);
`endif
        end
        cnt = LANES;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < LANES; i++) begin
                if (2*i + 1 < cnt) begin
                    // Strict greater-than keeps the lower-index element on ties.
                    if (val[2*i+1] > val[2*i]) begin
                        val[i] = val[2*i+1];
`ifdef MAX_REDUCE_ARGMAX_EN
                        id[i] = id[2*i+1];
`endif
                    end else begin
                        val[i] = val[2*i];
`ifdef MAX_REDUCE_ARGMAX_EN
                        id[i] = id[2*i];
`endif
                    end
                end else if (2*i < cnt) begin
                    val[i] = val[2*i];
`ifdef MAX_REDUCE_ARGMAX_EN
                    id[i] = id[2*i];
`endif
                end
            end
            cnt = (cnt + 1) / 2;
        end
        max_o = val[0];
`ifdef MAX_REDUCE_ARGMAX_EN
        idx_o = id[0];
`endif
    end

endmodule

// File: rtl/max_reduce_stream.sv
// Multi-lane streaming signed-max reducer feeding the softmax exponent stage.
// Define MAX_REDUCE_ARGMAX_EN to add max_idx_o (element index of the maximum).
//
// state | meaning
// IDLE  | waiting for start_i
// ACCUM | accepting beats, folding each beat maximum into the accumulator
// HOLD  | result presented, waiting for max_ready_i
module max_reduce_stream
    import softmax_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int NUM_DATA  = 10,
    parameter int LANES     = 4,
    localparam int IDX_W    = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic                       valid_i,
    input  logic [LANES*DATA_SIZE-1:0] data_i,
    output logic                       ready_o,
    output logic [DATA_SIZE-1:0]       data_max_o,
    output logic                       max_valid_o,
    input  logic                       max_ready_i,
`ifdef MAX_REDUCE_ARGMAX_EN
    output logic [IDX_W-1:0]           max_idx_o,
`endif
    output logic                       busy_o
);

    localparam int BEATS = beat_count(NUM_DATA, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [DATA_SIZE-1:0] MOST_NEG  = DATA_SIZE'(most_neg(DATA_SIZE));

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]   acc_q, acc_d;
    logic [LANES-1:0]       lane_mask;
    logic [DATA_SIZE-1:0]   beat_max;
`ifdef MAX_REDUCE_ARGMAX_EN
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [LW-1:0]          lane_idx;
`endif

    // Lanes past the end of the vector on the partial last beat never compete.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k] = (int'(cnt_q) * LANES + k) < NUM_DATA;
        end
    end

    max_lane_tree #(
        .DATA_SIZE (DATA_SIZE),
        .LANES     (LANES)
    ) u_tree (
        .data_i (data_i),
        .mask_i (lane_mask),
`ifdef MAX_REDUCE_ARGMAX_EN
        .idx_o  (lane_idx),
`endif
        .max_o  (beat_max)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`ifdef MAX_REDUCE_ARGMAX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = MOST_NEG;
`ifdef MAX_REDUCE_ARGMAX_EN
                    idx_d   = '0;
`endif
                end
            end
            ACCUM: begin
                if (valid_i) begin
                    // Earlier beats win ties, so only a strictly larger beat max replaces.
                    if ($signed(beat_max) > $signed(acc_q)) begin
                        acc_d = beat_max;
`ifdef MAX_REDUCE_ARGMAX_EN
                        idx_d = IDX_W'(int'(cnt_q) * LANES + int'(lane_idx));
`endif
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (max_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= MOST_NEG;
`ifdef MAX_REDUCE_ARGMAX_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`ifdef MAX_REDUCE_ARGMAX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign ready_o     = (state_q == ACCUM);
    assign busy_o      = (state_q != IDLE);
    assign max_valid_o = (state_q == HOLD);
    assign data_max_o  = max_valid_o ? acc_q : '0;
`ifdef MAX_REDUCE_ARGMAX_EN
    assign max_idx_o   = max_valid_o ? idx_q : '0;
`endif

endmodule
